pool_layer_cfg: RTL and testbench
=================================

// Module: pool_layer_cfg
// PURPOSE
//  Next-generation pooling layer for the generated CNN top levels (LeNet-class nets).
//  Buffers one img_width x img_width image per channel, then pools it with a runtime max/avg mode.
//  Window size and stride are parameters; output width and saturation are configurable.
//  Output is streamed one output pixel per handshake, all channels in parallel, to the next layer.
// PARAMETERS
//  input_channels        6   channels pooled in parallel
//  img_width             24  input image width = height (pixels)
//  kernel_dim            2   pooling window edge K (K>=1, K<=img_width)
//  stride                2   window step in x and y (>=1)
//  datatype_size         8   input pixel width, unsigned
//  output_datatype_size  8   output pixel width, unsigned
//  Derived: out_w = (img_width-kernel_dim)/stride + 1; acc_w = datatype_size + $clog2(K*K+1)
// PORTS
//  clk              in   1                               clock
//  rst              in   1                               sync reset, active-low
//  i_ibuf_we        in   1                               write one pixel (all channels)
//  i_ibuf_wr_data   in   [datatype_size-1:0] x ch        pixel data, one per channel
//  i_start          in   1                               start pooling the buffered image
//  i_mode           in   1                               0=max, 1=avg; sampled on accepted i_start
//  i_next_busy      in   1                               downstream stall
//  o_busy           out  1                               pooling run in progress
//  o_valid          out  1                               o_func_data holds an output pixel
//  o_func_data      out  [output_datatype_size-1:0] x ch pooled pixel per channel
//  o_done           out  1                               one-cycle pulse after the last pixel is accepted
// BEHAVIOUR
//  Reset (rst==0 at posedge): FSM=IDLE; write ptr, ox, oy, kx, ky := 0.
//   o_busy, o_valid, o_done := 0; o_func_data := 0. Buffer contents are don't-care.
//  Write: in IDLE, i_ibuf_we stores data at wr_ptr (raster order) and increments wr_ptr.
//   wr_ptr wraps from img_width^2-1 to 0. Writes are ignored while o_busy=1.
//  i_start is accepted only in IDLE. An accepted start latches i_mode and resets ox/oy/kx/ky/wr_ptr.
//   o_busy goes to 1 on the next cycle. i_start while busy is ignored.
//   A write and a start in the same cycle: the write is performed first.
//  FSM states:
//   IDLE -> READ on accepted start.
//   READ: one buffer read per cycle at (oy*stride+ky)*img_width + ox*stride+kx.
//    kx runs fastest, then ky; K*K cycles per output pixel.
//   ACC: sync-RAM read latency is 1 cycle, and the last window read is folded in here.
//   READ -> ACC after kx=ky=K-1.
//   ACC -> EMIT with the result registered.
//   EMIT: o_valid=1; o_func_data is held stable while i_next_busy=1.
//    When i_next_busy=0, the pixel is accepted and o_valid drops next cycle.
//    ox advances, then oy. Next state is READ, or DONE after (out_w-1, out_w-1).
//   DONE: o_done=1 for one cycle, o_busy=0 from the same cycle -> IDLE.
//  Minimum cycles per output pixel: K*K + 2.
//  Total for an unstalled run: out_w^2*(K*K+2) + 2 cycles, from start accept to o_done.
//  Arithmetic, independent per channel:
//   max = running unsigned max, seeded with the first window pixel.
//   avg = floor(sum / (K*K)); sum is acc_w bits wide and never overflows.
//   Constant divide; shift when K*K is a power of two.
//  Output width: if the result exceeds 2^output_datatype_size-1, saturate to all-ones.
//   Otherwise zero-extend.
//  Window pixels beyond out_w*stride coverage are never read (floor semantics, no padding).
//  Reset mid-run: all state is cleared immediately; no o_done is issued.
// TESTING
//  T1: ch=2, W=4, K=2, s=2, max mode; ch0 = ramp 0..15, ch1 = 15-ramp.
//   -> ch0 outputs 5, 7, 13, 15; ch1 outputs 15, 13, 7, 5.
//   -> then o_done; 4*(4+2)+2 = 26 cycles.
//  T2: same image, avg mode -> ch0 outputs 2, 4, 10, 12.
//  T3: W=4, K=3, s=1, max mode, ramp -> outputs 10, 11, 14, 15.
//   avg mode gives floor(45/9)=5, 6, 9, 10.
//  T4: hold i_next_busy=1 for 7 cycles during the 2nd EMIT.
//   -> o_valid stays 1 with stable data; no pixel is lost or duplicated; o_done is delayed by 7 cycles.
//  T5: all pixels 255, avg, output_datatype_size=4 -> every output = 15 (saturated).
//   With output_datatype_size=8 -> 255.
//  T6: assert rst=0 during the 3rd READ.
//   -> outputs are 0 next cycle, FSM is IDLE, no o_done.
//   -> a new 16-pixel load plus start then reproduces T1 exactly.
//   -> i_start while busy and i_ibuf_we while busy have no effect.

Source files
------------

// File: rtl/pool_layer_cfg.sv
// pool_layer_cfg: image-buffered pooling layer for CNN pipelines.
// Loads one img_width x img_width image per channel into a sync-read buffer,
// then walks K x K windows at the configured stride. Each window reduces to
// its max or its floor average, which is saturated to the output width and
// offered downstream through a valid/busy handshake. All channels are
// processed in parallel.
module pool_layer_cfg #(
  parameter int input_channels       = 6,
  parameter int img_width            = 24,
  parameter int kernel_dim           = 2,
  parameter int stride               = 2,
  parameter int datatype_size        = 8,
  parameter int output_datatype_size = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                i_ibuf_we,
  input  logic [input_channels-1:0][datatype_size-1:0]        i_ibuf_wr_data,
  input  logic                                                i_start,
  input  logic                                                i_mode,
  input  logic                                                i_next_busy,
  output logic                                                o_busy,
  output logic                                                o_valid,
  output logic [input_channels-1:0][output_datatype_size-1:0] o_func_data,
  output logic                                                o_done
);

  localparam int OUT_W   = (img_width - kernel_dim) / stride + 1;
  localparam int KK      = kernel_dim * kernel_dim;
  localparam int ACC_W   = datatype_size + $clog2(KK + 1);
  localparam int DEPTH   = img_width * img_width;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = $clog2(img_width + 1);
  localparam bit KK_POW2 = ((KK & (KK - 1)) == 0);
  localparam int KK_SH   = $clog2(KK);
  localparam int RW      = (ACC_W > output_datatype_size) ? ACC_W : output_datatype_size;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ACC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                                               state_q;
  logic [AW-1:0]                                        wr_ptr_q;
  logic [CW-1:0]                                        ox_q, oy_q, kx_q, ky_q;
  logic                                                 mode_q;
  logic                                                 busy_q, valid_q, done_q;
  logic [input_channels-1:0][output_datatype_size-1:0]  func_q;
  logic [input_channels-1:0][ACC_W-1:0]                 acc_q;
  logic                                                 rd_vld_q, rd_first_q;

  logic [input_channels-1:0][datatype_size-1:0]         mem [DEPTH];
  logic [input_channels-1:0][datatype_size-1:0]         rd_data_q;
  logic [AW-1:0]                                        rd_addr;

  logic [input_channels-1:0][ACC_W-1:0]                 fold_d;
  logic [input_channels-1:0][output_datatype_size-1:0]  func_d;

  // Divide by the window area; the power-of-two case reduces to a shift.
  function automatic logic [ACC_W-1:0] kk_div(input logic [ACC_W-1:0] x);
    if (KK_POW2) return x >> KK_SH;
    else         return x / ACC_W'(KK);
  endfunction

  // Buffer address of the current window pixel in raster order.
  always_comb begin
    logic [31:0] row, col;
    row     = 32'(oy_q) * 32'(stride) + 32'(ky_q);
    col     = 32'(ox_q) * 32'(stride) + 32'(kx_q);
    rd_addr = AW'(row * 32'(img_width) + col);
  end

  // Image buffer: writes only while idle, one registered read per cycle.
  // NOTE: the buffer has no reset; its contents are rewritten before use and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && i_ibuf_we) mem[wr_ptr_q] <= i_ibuf_wr_data;
    rd_data_q <= mem[rd_addr];
  end

  // Fold the pixel read last cycle into each channel and form the saturated result.
  // NOTE: every always_comb output is assigned a default first so no latch can be inferred.
  always_comb begin
    fold_d = acc_q;
    func_d = '0;
    for (int c = 0; c < input_channels; c++) begin
      logic [ACC_W-1:0] pix, res;
      logic [RW-1:0]    res_ext, omax;
      pix = ACC_W'(rd_data_q[c]);
      if (rd_first_q)  fold_d[c] = pix;
      else if (mode_q) fold_d[c] = acc_q[c] + pix;
      else             fold_d[c] = (pix > acc_q[c]) ? pix : acc_q[c];
      res       = mode_q ? kk_div(fold_d[c]) : fold_d[c];
      res_ext   = RW'(res);
      omax      = RW'({output_datatype_size{1'b1}});
      func_d[c] = (res_ext > omax) ? {output_datatype_size{1'b1}}
                                   : output_datatype_size'(res_ext);
    end
  end

  // Control FSM with registered outputs and window/accumulator bookkeeping.
  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      func_q     <= '0;
      acc_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_vld_q   <= (state_q == S_READ);
      rd_first_q <= (state_q == S_READ) && (kx_q == '0) && (ky_q == '0);
      if (rd_vld_q) acc_q <= fold_d;

      case (state_q)
        S_IDLE: begin
          if (i_ibuf_we)
            wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
          // A start in the same cycle as a write overrides the pointer after the write lands.
          if (i_start) begin
            mode_q   <= i_mode;
            wr_ptr_q <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            kx_q     <= '0;
            ky_q     <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          if (kx_q == CW'(kernel_dim - 1)) begin
            kx_q <= '0;
            if (ky_q == CW'(kernel_dim - 1)) begin
              ky_q    <= '0;
              state_q <= S_ACC;
            end else begin
              ky_q <= ky_q + 1'b1;
            end
          end else begin
            kx_q <= kx_q + 1'b1;
          end
        end
        S_ACC: begin
          func_q  <= func_d;
          valid_q <= 1'b1;
          state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (!i_next_busy) begin
            valid_q <= 1'b0;
            state_q <= S_READ;
            if (ox_q == CW'(OUT_W - 1)) begin
              ox_q <= '0;
              if (oy_q == CW'(OUT_W - 1)) begin
                oy_q    <= '0;
                state_q <= S_DONE;
              end else begin
                oy_q <= oy_q + 1'b1;
              end
            end else begin
              ox_q <= ox_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_func_data = func_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_pool_layer_cfg.sv
// Directed bench for pool_layer_cfg: three instances (K=2/s=2, K=3/s=1,
// K=2/s=2 with 4-bit output) share the load bus, each with its own start.
module tb_pool_layer_cfg;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_ibuf_we;
  logic [1:0][7:0]      i_ibuf_wr_data;
  logic [2:0]           start_v;
  logic                 i_mode;
  logic                 i_next_busy;

  logic                 a_busy, a_valid, a_done;
  logic [1:0][7:0]      a_data;
  logic                 b_busy, b_valid, b_done;
  logic [1:0][7:0]      b_data;
  logic                 c_busy, c_valid, c_done;
  logic [1:0][3:0]      c_data;

  int                   sel;
  logic                 sel_busy, sel_valid, sel_done;
  int                   sel_d0, sel_d1;

  int                   n_checks = 0;
  int                   n_pass   = 0;
  int                   exp0[4];
  int                   exp1[4];

  always #5 clk = ~clk;

  pool_layer_cfg #(.input_channels(2), .img_width(4), .kernel_dim(2), .stride(2),
                   .datatype_size(8), .output_datatype_size(8)) dut_a (
    .clk(clk), .rst(rst), .i_ibuf_we(i_ibuf_we), .i_ibuf_wr_data(i_ibuf_wr_data),
    .i_start(start_v[0]), .i_mode(i_mode), .i_next_busy(i_next_busy),
    .o_busy(a_busy), .o_valid(a_valid), .o_func_data(a_data), .o_done(a_done));

  pool_layer_cfg #(.input_channels(2), .img_width(4), .kernel_dim(3), .stride(1),
                   .datatype_size(8), .output_datatype_size(8)) dut_b (
    .clk(clk), .rst(rst), .i_ibuf_we(i_ibuf_we), .i_ibuf_wr_data(i_ibuf_wr_data),
    .i_start(start_v[1]), .i_mode(i_mode), .i_next_busy(i_next_busy),
    .o_busy(b_busy), .o_valid(b_valid), .o_func_data(b_data), .o_done(b_done));

  pool_layer_cfg #(.input_channels(2), .img_width(4), .kernel_dim(2), .stride(2),
                   .datatype_size(8), .output_datatype_size(4)) dut_c (
    .clk(clk), .rst(rst), .i_ibuf_we(i_ibuf_we), .i_ibuf_wr_data(i_ibuf_wr_data),
    .i_start(start_v[2]), .i_mode(i_mode), .i_next_busy(i_next_busy),
    .o_busy(c_busy), .o_valid(c_valid), .o_func_data(c_data), .o_done(c_done));

  // Route the instance under test to common observation signals.
  always_comb begin
    sel_busy  = 1'b0;
    sel_valid = 1'b0;
    sel_done  = 1'b0;
    sel_d0    = 0;
    sel_d1    = 0;
    case (sel)
      0: begin
        sel_busy = a_busy; sel_valid = a_valid; sel_done = a_done;
        sel_d0 = int'(a_data[0]); sel_d1 = int'(a_data[1]);
      end
      1: begin
        sel_busy = b_busy; sel_valid = b_valid; sel_done = b_done;
        sel_d0 = int'(b_data[0]); sel_d1 = int'(b_data[1]);
      end
      default: begin
        sel_busy = c_busy; sel_valid = c_valid; sel_done = c_done;
        sel_d0 = int'(c_data[0]); sel_d1 = int'(c_data[1]);
      end
    endcase
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // pat 0: ch0 = ramp 0..15, ch1 = 15-ramp; pat 1: every pixel 255.
  task automatic load(input int pat);
    for (int i = 0; i < 16; i++) begin
      i_ibuf_we         = 1'b1;
      i_ibuf_wr_data[0] = (pat == 1) ? 8'd255 : 8'(i);
      i_ibuf_wr_data[1] = (pat == 1) ? 8'd255 : 8'(15 - i);
      @(posedge clk); #1;
    end
    i_ibuf_we = 1'b0;
  endtask

  // Start one instance, collect its four output pixels, optionally stall one
  // of them, optionally poke a start plus write while busy, and time o_done.
  task automatic run(input int s, input bit mode, input int stall_idx, input int stall_len,
                     input int exp_cyc, input int poke, input string tag);
    int cyc, idx, st_cnt, h0, h1;
    bit done_seen;
    sel        = s;
    i_mode     = mode;
    start_v[s] = 1'b1;
    @(posedge clk); #1;
    start_v    = '0;
    cyc = 1; idx = 0; st_cnt = 0; h0 = 0; h1 = 0; done_seen = 1'b0;
    check($sformatf("%s busy_after_start", tag), int'(sel_busy), 1);
    while (!done_seen && cyc < 400) begin
      start_v     = '0;
      i_ibuf_we   = 1'b0;
      i_next_busy = 1'b0;
      if (sel_done) begin
        done_seen = 1'b1;
      end else begin
        if (cyc == poke) begin
          start_v[s]     = 1'b1;
          i_mode         = ~mode;
          i_ibuf_we      = 1'b1;
          i_ibuf_wr_data = {8'd99, 8'd99};
        end
        if (sel_valid) begin
          if (idx == stall_idx && st_cnt < stall_len) begin
            if (st_cnt == 0) begin
              h0 = sel_d0;
              h1 = sel_d1;
            end
            i_next_busy = 1'b1;
            st_cnt++;
          end else begin
            if (idx == stall_idx && stall_len > 0) begin
              check($sformatf("%s stall_hold ch0", tag), sel_d0, h0);
              check($sformatf("%s stall_hold ch1", tag), sel_d1, h1);
            end
            if (idx < 4) begin
              check($sformatf("%s pix%0d ch0", tag, idx), sel_d0, exp0[idx]);
              check($sformatf("%s pix%0d ch1", tag, idx), sel_d1, exp1[idx]);
            end
            idx++;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start_v     = '0;
    i_ibuf_we   = 1'b0;
    i_next_busy = 1'b0;
    check($sformatf("%s done_seen", tag), int'(done_seen), 1);
    check($sformatf("%s cycles_to_done", tag), cyc, exp_cyc);
    check($sformatf("%s pixel_count", tag), idx, 4);
    check($sformatf("%s busy_at_done", tag), int'(sel_busy), 0);
    @(posedge clk); #1;
    check($sformatf("%s done_one_cycle", tag), int'(sel_done), 0);
  endtask

  initial begin
    int done_cnt;
    rst            = 1'b0;
    i_ibuf_we      = 1'b0;
    i_ibuf_wr_data = '0;
    start_v        = '0;
    i_mode         = 1'b0;
    i_next_busy    = 1'b0;
    sel            = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(sel_busy), 0);
    check("reset valid", int'(sel_valid), 0);
    check("reset done", int'(sel_done), 0);
    check("reset data ch0", sel_d0, 0);
    check("reset data ch1", sel_d1, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: max over 2x2/s2 windows of the ramp image.
    load(0);
    exp0 = '{5, 7, 13, 15};
    exp1 = '{15, 13, 7, 5};
    run(0, 1'b0, -1, 0, 26, -1, "T1");

    // T2: same buffered image, average mode.
    exp0 = '{2, 4, 10, 12};
    exp1 = '{12, 10, 4, 2};
    run(0, 1'b1, -1, 0, 26, -1, "T2");

    // T3: 3x3 windows at stride 1, max then average.
    exp0 = '{10, 11, 14, 15};
    exp1 = '{15, 14, 11, 10};
    run(1, 1'b0, -1, 0, 46, -1, "T3max");
    exp0 = '{5, 6, 9, 10};
    exp1 = '{10, 9, 6, 5};
    run(1, 1'b1, -1, 0, 46, -1, "T3avg");

    // T5: saturated image; 4-bit output clips to 15, 8-bit output keeps 255.
    load(1);
    exp0 = '{15, 15, 15, 15};
    exp1 = '{15, 15, 15, 15};
    run(2, 1'b1, -1, 0, 26, -1, "T5o4");
    exp0 = '{255, 255, 255, 255};
    exp1 = '{255, 255, 255, 255};
    run(0, 1'b1, -1, 0, 26, -1, "T5o8");

    // T4: stall the second output for 7 cycles.
    load(0);
    exp0 = '{5, 7, 13, 15};
    exp1 = '{15, 13, 7, 5};
    run(0, 1'b0, 1, 7, 33, -1, "T4");

    // T6: reset during the third READ cycle of a run.
    sel        = 0;
    i_mode     = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("T6 busy_before_reset", int'(sel_busy), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("T6 busy_after_reset", int'(sel_busy), 0);
    check("T6 valid_after_reset", int'(sel_valid), 0);
    check("T6 data_after_reset", sel_d0, 0);
    rst      = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (sel_done) done_cnt++;
    end
    check("T6 no_done_after_reset", done_cnt, 0);
    check("T6 idle_busy", int'(sel_busy), 0);

    // Rerun T1 with a start and a write poked in while busy.
    load(0);
    exp0 = '{5, 7, 13, 15};
    exp1 = '{15, 13, 7, 5};
    run(0, 1'b0, -1, 0, 26, 5, "T6rerun");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
